// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/return sequencer with timeslice timer.
// Arbitrates the hardware mepc save against software bus writes.
module trap_sequencer #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int          TIMESLICE   = 1000
) (
  input  logic        clock,
  input  logic        resetActiveLow,
  input  logic        irqEnable,
  input  logic        extIrq,
  input  logic        instrRetire,
  input  logic [31:0] pcNext,
  input  logic        mretValid,
  input  logic        busMepcWrite,
  input  logic [31:0] mepcValue,
  output logic        csrWriteEnable,
  output logic [31:0] pcFromCore,
  output logic        pcRedirectValid,
  output logic [31:0] pcRedirectTarget,
  output logic        stallCore,
  output logic        inTrap,
  output logic        trapCause,
  output logic        timerPending
);

  localparam logic [15:0] RELOAD = 16'(TIMESLICE - 1);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    REDIRECT,
    HANDLER,
    RETURN
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [15:0] count;
  logic        pending;
  logic        accept;
  logic        tick;

  assign pending = timerPending | extIrq;
  assign accept  = (state == IDLE) & pending
                 & irqEnable & instrRetire;
  // Timer only runs while no trap is in flight.
  assign tick    = (state == IDLE) & (count == 16'd0);

  always_ff @(posedge clock) begin
    if (!resetActiveLow) begin
      state        <= IDLE;
      count        <= RELOAD;
      timerPending <= 1'b0;
      pcFromCore   <= 32'd0;
      trapCause    <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE) begin
        if (tick) begin
          count <= RELOAD;
        end else begin
          count <= count - 16'd1;
        end
      end
      // A tick landing on a pending tick is absorbed.
      if (accept && timerPending) begin
        timerPending <= 1'b0;
      end else if (tick) begin
        timerPending <= 1'b1;
      end
      if (accept) begin
        pcFromCore <= pcNext;
        trapCause  <= timerPending;
      end
    end
  end

  always_comb begin
    stateNext        = state;
    csrWriteEnable   = 1'b0;
    pcRedirectValid  = 1'b0;
    pcRedirectTarget = 32'd0;
    stallCore        = 1'b0;
    inTrap           = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stateNext = SAVE;
        end
      end
      SAVE: begin
        stallCore = 1'b1;
        // Bus owns the mepc write port; retry until it is idle.
        if (!busMepcWrite) begin
          csrWriteEnable = 1'b1;
          stateNext      = REDIRECT;
        end
      end
      REDIRECT: begin
        stallCore        = 1'b1;
        pcRedirectValid  = 1'b1;
        pcRedirectTarget = TRAP_VECTOR;
        stateNext        = HANDLER;
      end
      HANDLER: begin
        inTrap = 1'b1;
        if (mretValid) begin
          stateNext = RETURN;
        end
      end
      RETURN: begin
        stallCore        = 1'b1;
        pcRedirectValid  = 1'b1;
        pcRedirectTarget = mepcValue;
        stateNext        = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: vector table, directed corners,
// randomized run against a behavioural reference model.
module tb_trap_sequencer;

  localparam int TS = 8;

  logic        clock = 1'b0;
  logic        resetActiveLow;
  logic        irqEnable;
  logic        extIrq;
  logic        instrRetire;
  logic [31:0] pcNext;
  logic        mretValid;
  logic        busMepcWrite;
  logic [31:0] mepcValue;
  logic        csrWriteEnable;
  logic [31:0] pcFromCore;
  logic        pcRedirectValid;
  logic [31:0] pcRedirectTarget;
  logic        stallCore;
  logic        inTrap;
  logic        trapCause;
  logic        timerPending;

  logic [31:0] busData;
  logic [31:0] mepcReg = 32'd0;

  int nTotal = 0;
  int nPass  = 0;

  trap_sequencer #(
    .TRAP_VECTOR(32'h0000_0100),
    .TIMESLICE  (TS)
  ) dut (
    .clock           (clock),
    .resetActiveLow  (resetActiveLow),
    .irqEnable       (irqEnable),
    .extIrq          (extIrq),
    .instrRetire     (instrRetire),
    .pcNext          (pcNext),
    .mretValid       (mretValid),
    .busMepcWrite    (busMepcWrite),
    .mepcValue       (mepcValue),
    .csrWriteEnable  (csrWriteEnable),
    .pcFromCore      (pcFromCore),
    .pcRedirectValid (pcRedirectValid),
    .pcRedirectTarget(pcRedirectTarget),
    .stallCore       (stallCore),
    .inTrap          (inTrap),
    .trapCause       (trapCause),
    .timerPending    (timerPending)
  );

  always #5 clock = ~clock;

  // CSR block stand-in: bus write has priority over hardware save.
  always @(posedge clock) begin
    if (busMepcWrite) begin
      mepcReg <= busData;
    end else if (csrWriteEnable) begin
      mepcReg <= pcFromCore;
    end
  end
  assign mepcValue = mepcReg;

  function automatic logic [69:0] ev(
    input logic we, input logic [31:0] pcf,
    input logic rv, input logic [31:0] tgt,
    input logic st, input logic it,
    input logic tc, input logic tp);
    return {we, pcf, rv, tgt, st, it, tc, tp};
  endfunction

  function automatic logic [69:0] outVec();
    return {csrWriteEnable, pcFromCore,
            pcRedirectValid, pcRedirectTarget,
            stallCore, inTrap, trapCause, timerPending};
  endfunction

  task automatic chk(input string nm,
                     input logic [69:0] got,
                     input logic [69:0] exp);
    nTotal++;
    if (got === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic ie, input logic ex,
                       input logic rt, input logic [31:0] pc,
                       input logic mr, input logic bw,
                       input logic [31:0] bd);
    irqEnable    = ie;
    extIrq       = ex;
    instrRetire  = rt;
    pcNext       = pc;
    mretValid    = mr;
    busMepcWrite = bw;
    busData      = bd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        ie;
    logic        ex;
    logic        rt;
    logic [31:0] pc;
    logic        mr;
    logic        bw;
    logic [31:0] bd;
    logic [69:0] exp;
  } vec_t;

  vec_t tbl[15];

  // Reference model state
  int          mSt;
  int          mIdle;
  bit          mTp;
  bit          mCause;
  logic [31:0] mPc;
  logic [31:0] mMepc;

  initial begin
    int n;
    resetActiveLow = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    for (int k = 0; k < 15; k++) begin
      tbl[k] = '{1'b1, 1'b0, 1'b1, 32'h40 + 32'(4 * k),
                 1'b0, 1'b0, 32'd0, ev(0, 0, 0, 0, 0, 0, 0, 0)};
    end
    tbl[8].exp  = ev(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[9].exp  = ev(1, 32'h60, 0, 0, 1, 0, 1, 0);
    tbl[10].exp = ev(0, 32'h60, 1, 32'h100, 1, 0, 1, 0);
    tbl[11].exp = ev(0, 32'h60, 0, 0, 0, 1, 1, 0);
    tbl[12].exp = ev(0, 32'h60, 0, 0, 0, 1, 1, 0);
    tbl[12].mr  = 1'b1;
    tbl[12].bw  = 1'b1;
    tbl[12].bd  = 32'h2000;
    tbl[13].exp = ev(0, 32'h60, 1, 32'h2000, 1, 0, 1, 0);
    tbl[14].exp = ev(0, 32'h60, 0, 0, 0, 0, 1, 0);

    step();
    step();
    chk("reset", outVec(), ev(0, 0, 0, 0, 0, 0, 0, 0));
    resetActiveLow = 1'b1;

    // Timer trap, context switch through mret
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].ie, tbl[k].ex, tbl[k].rt, tbl[k].pc,
            tbl[k].mr, tbl[k].bw, tbl[k].bd);
      @(negedge clock);
      chk($sformatf("vec%0d", k), outVec(), tbl[k].exp);
      step();
    end

    // External trap with bus collision during SAVE
    drive(1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("coll%0d", k),
          {68'd0, csrWriteEnable, stallCore}, {68'd0, 2'b01});
      step();
    end
    busMepcWrite = 1'b0;
    @(negedge clock);
    chk("collSave", outVec(),
        ev(1, 32'h500, 0, 0, 1, 0, 0, 0));
    step();
    @(negedge clock);
    chk("collRedir", outVec(),
        ev(0, 32'h500, 1, 32'h100, 1, 0, 0, 0));
    step();
    @(negedge clock);
    chk("collHandler", outVec(),
        ev(0, 32'h500, 0, 0, 0, 1, 0, 0));
    chk("collMepc", {38'd0, mepcValue}, {38'd0, 32'h500});

    // Reset mid-handler
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    resetActiveLow = 1'b0;
    step();
    chk("rstHandler", outVec(), ev(0, 0, 0, 0, 0, 0, 0, 0));
    resetActiveLow = 1'b1;
    n = 0;
    while (!timerPending && n < 50) begin
      step();
      n++;
    end
    chk("reloadTicks", {38'd0, 32'(n)}, {38'd0, 32'(TS)});

    // Randomized run against the reference model
    resetActiveLow = 1'b0;
    step();
    resetActiveLow = 1'b1;
    mSt = 0; mIdle = 0; mTp = 0; mCause = 0; mPc = 0;
    mMepc = mepcReg;
    for (int c = 0; c < 3000; c++) begin
      logic ewe;
      logic erv;
      logic [31:0] etg;
      logic acc;
      logic tk;
      resetActiveLow = ($urandom % 200) != 0;
      drive(($urandom % 4) != 0, ($urandom % 6) == 0,
            $urandom % 2, $urandom, ($urandom % 5) == 0,
            ($urandom % 3) == 0, $urandom);
      @(negedge clock);
      ewe = (mSt == 1) && !busMepcWrite;
      erv = (mSt == 2) || (mSt == 4);
      etg = (mSt == 2) ? 32'h100 : (mSt == 4) ? mMepc : 32'd0;
      chk("rand", outVec(),
          ev(ewe, mPc, erv, etg, mSt == 1 || erv,
             mSt == 3, mCause, mTp));
      @(posedge clock);
      if (busMepcWrite) begin
        mMepc = busData;
      end else if (ewe) begin
        mMepc = mPc;
      end
      if (!resetActiveLow) begin
        mSt = 0; mIdle = 0; mTp = 0; mCause = 0; mPc = 0;
      end else begin
        tk  = (mSt == 0) && (mIdle % TS == TS - 1);
        acc = (mSt == 0) && (mTp || extIrq)
            && irqEnable && instrRetire;
        if (mSt == 0) begin
          mIdle++;
        end
        case (mSt)
          0: if (acc) begin
               mPc = pcNext;
               mCause = mTp;
               mSt = 1;
             end
          1: if (!busMepcWrite) mSt = 2;
          2: mSt = 3;
          3: if (mretValid) mSt = 4;
          default: mSt = 0;
        endcase
        if (acc && mCause) begin
          mTp = 0;
        end else if (tk) begin
          mTp = 1;
        end
      end
      #1;
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
